seg_page_scanner: RTL

Parametrised multi-digit, multi-page seven-segment display controller for the board's Hamming encode/decode status display. It time-multiplexes N_DIGITS common-anode digits from a packed nibble bus holding N_PAGES pages of data. A debounced push-button steps through the pages cyclically. It supersedes the two-display toggle scheme and adds counter-based debounce, scan multiplexing, per-digit blanking and N-way paging.

---
 rtl/seg_page_scanner.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_page_scanner.sv
// ---------------------------------------------------------------------------
// seg_page_scanner
//
// Multi-digit, multi-page seven-segment scanner for the Hamming encode/decode
// status display. One common-anode digit is lit per scan slot. A debounced
// push-button steps cyclically through N_PAGES pages of nibble data.
//
// Optional feature (compile-time macro): SEG_LEAD_ZERO_BLANK_EN
//   Defined   : an enabled digit d>0 is also blanked when its nibble and every
//               enabled nibble above it on the current page are zero.
//   Undefined : only digit_en blanks a digit; zero nibbles show "0".
//
// Parameters
//   N_DIGITS        digits physically driven (1..8)
//   N_PAGES         pages selectable by the button (1..8)
//   DEBOUNCE_CYCLES stability requirement of the synchronised button (>=1)
//   SCAN_DIV        clk cycles per digit slot (>=1)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   button     raw push-button, asynchronous, active-high
//   page_data  nibble (page p, digit d) at [(p*N_DIGITS+d)*4 +: 4], digit 0 rightmost
//   digit_en   bit p*N_DIGITS+d enables digit d of page p (0 = blank)
//   seg        segments {g,f,e,d,c,b,a}, active-low, registered
//   an         anode enables, active-low, one-hot-low, registered
//   page       currently selected page
// ---------------------------------------------------------------------------
module seg_page_scanner #(
  parameter int  N_DIGITS        = 4,
  parameter int  N_PAGES         = 2,
  parameter int  DEBOUNCE_CYCLES = 16,
  parameter int  SCAN_DIV        = 1024,
  localparam int PAGE_W          = (N_PAGES > 1) ? $clog2(N_PAGES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          button,
  input  logic [N_PAGES*N_DIGITS*4-1:0] page_data,
  input  logic [N_PAGES*N_DIGITS-1:0]   digit_en,
  output logic [6:0]                    seg,
  output logic [N_DIGITS-1:0]           an,
  output logic [PAGE_W-1:0]             page
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  // Active-low hex decode for a common-anode digit.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h40;
      4'h1: code = 7'h79;
      4'h2: code = 7'h24;
      4'h3: code = 7'h30;
      4'h4: code = 7'h19;
      4'h5: code = 7'h12;
      4'h6: code = 7'h02;
      4'h7: code = 7'h78;
      4'h8: code = 7'h00;
      4'h9: code = 7'h10;
      4'hA: code = 7'h08;
      4'hB: code = 7'h03;
      4'hC: code = 7'h46;
      4'hD: code = 7'h21;
      4'hE: code = 7'h06;
      default: code = 7'h0E;
    endcase
    return code;
  endfunction

  // State
  logic              sync1_q, sync2_q;
  logic              db_lvl_q, db_lvl_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  // Current page split into per-digit nibbles and enables.
  logic [3:0]          cur_nib [N_DIGITS];
  logic [N_DIGITS-1:0] cur_en;
  logic [N_DIGITS-1:0] lz_blank;
  logic [3:0]          sel_nib;
  logic                sel_on;

  always_comb begin
    for (int d = 0; d < N_DIGITS; d++) begin
      cur_nib[d] = page_data[(int'(page_q) * N_DIGITS + d) * 4 +: 4];
      cur_en[d]  = digit_en[int'(page_q) * N_DIGITS + d];
    end
  end

`ifdef SEG_LEAD_ZERO_BLANK_EN
  // Walk from the most significant digit down; zero_above stays set while
  // every enabled nibble seen so far is zero. Disabled digits are skipped so
  // they neither break nor extend the run of leading zeros.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int d = N_DIGITS - 1; d >= 0; d--) begin
      if (cur_en[d]) begin
        if (d > 0 && cur_nib[d] == 4'h0 && zero_above) lz_blank[d] = 1'b1;
        zero_above = zero_above & (cur_nib[d] == 4'h0);
      end
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Mux the scanned digit by comparison rather than array indexing so the
  // select stays well-formed for any N_DIGITS, including 1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sel_nib = 4'h0;
    sel_on  = 1'b0;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (idx_q == IDX_W'(d)) begin
        sel_nib = cur_nib[d];
        sel_on  = cur_en[d] & ~lz_blank[d];
      end
    end
  end

  always_comb begin
    db_lvl_d = db_lvl_q;
    db_cnt_d = db_cnt_q;
    page_d   = page_q;
    pre_d    = pre_q;
    idx_d    = idx_q;

    // Debounce: the counter tracks how long the synchronised button has
    // disagreed with the accepted level. The level flips on the disagreeing
    // sample that finds the counter already at DEBOUNCE_CYCLES, so a press is
    // accepted DEBOUNCE_CYCLES+2 edges after the raw button is first captured.
    if (sync2_q == db_lvl_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
      db_lvl_d = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end

    // Only the press edge pages; release and holding do nothing.
    if (!db_lvl_q && db_lvl_d) begin
      page_d = (page_q == PAGE_W'(N_PAGES - 1)) ? '0 : page_q + 1'b1;
    end

    // Scan timing is independent of paging.
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end

    // Outputs reflect the state before this edge; a blanked digit keeps its
    // anode active so the scan duty cycle is unchanged.
    an_d  = ~(N_DIGITS'(1) << idx_q);
    seg_d = sel_on ? hex7(sel_nib) : 7'h7F;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_lvl_q <= 1'b0;
      db_cnt_q <= '0;
      page_q   <= '0;
      pre_q    <= '0;
      idx_q    <= '0;
      seg_q    <= 7'h7F;
      an_q     <= '1;
    end else begin
      sync1_q  <= button;
      sync2_q  <= sync1_q;
      db_lvl_q <= db_lvl_d;
      db_cnt_q <= db_cnt_d;
      page_q   <= page_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign page = page_q;

endmodule
